// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with done pulse and optional auto-reload.
// Latency: q updates on the edge sampling load/slowena; done is high the cycle after that edge.
// Backpressure: none; slowena is a free-running strobe, and load takes priority over it.
module bcd_down_timer #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    input  logic                slowena,
    output logic [4*DIGITS-1:0] q,
    output logic                running,
    output logic                done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   reload_val;
    logic [W-1:0]   din_san;
    logic [W-1:0]   q_dec;
    logic           q_is_one;
    logic           din_zero;

    // Out-of-range digits clamp to 9 so the counter never holds a non-BCD digit.
    always_comb begin
        din_san = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (din[4*i +: 4] > 4'd9)
                din_san[4*i +: 4] = 4'd9;
            else
                din_san[4*i +: 4] = din[4*i +: 4];
        end
    end

    // Digit-serial borrow chain; each digit stays in 0..9 independently.
    always_comb begin
        logic borrow;
        q_dec  = q;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (q[4*i +: 4] == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    assign q_is_one = (q == W'(1));
    assign din_zero = (din_san == '0);
    assign running  = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            q          <= '0;
            reload_val <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                q          <= din_san;
                reload_val <= din_san;
                state      <= din_zero ? IDLE : RUN;
            end else if (state == RUN && slowena) begin
                if (q_is_one) begin
                    done <= 1'b1;
                    if (AUTO_RELOAD) begin
                        q <= reload_val;
                    end else begin
                        q     <= '0;
                        state <= IDLE;
                    end
                end else begin
                    q <= q_dec;
                end
            end
        end
    end

endmodule
